// File: rtl/apb_arb_pkg.sv
// Shared types for the APB round-robin arbiter.
// FSM state encoding, latched request bundle, index-width helper.
package apb_arb_pkg;

  localparam int ARB_AW = 12;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  // Sized by the package widths; the
  // arbiter's width parameters default
  // to these values.
  typedef struct packed {
    logic [ARB_AW-1:0]   addr;
    logic                write;
    logic [ARB_DW-1:0]   wdata;
    logic [ARB_DW/8-1:0] strb;
  } req_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_sel.sv
// Combinational rotating-priority selector.
// i_req: request vector; i_last: last granted index; o_gnt: one-hot grant; o_idx: grant index.
module rr_arb_sel
  import apb_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);

  // Search starts just above the last
  // grant and wraps, so the last winner
  // has lowest priority.
  always_comb begin
    logic v_found;
    int   v_c;
    o_gnt   = '0;
    o_idx   = '0;
    v_found = 1'b0;
    v_c     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_c = (int'(i_last) + k) % NUM_REQ;
      if (!v_found && i_req[v_c]) begin
        v_found    = 1'b1;
        o_gnt[v_c] = 1'b1;
        o_idx      = IW'(v_c);
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin share of one APB4 master port with a pready watchdog.
// Ports: clk_i/rst_i; req_* per requester in, rsp_* out; APB p*; busy_o, timeout_o.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = ARB_AW,
  parameter int DATA_WIDTH     = ARB_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic                            pwrite_o,
  output logic [DATA_WIDTH-1:0]           pwdata_o,
  output logic [DATA_WIDTH/8-1:0]         pstrb_o,
  output logic                            psel_o,
  output logic                            penable_o,
  input  logic                            pready_i,
  input  logic                            pslverr_i,
  input  logic [DATA_WIDTH-1:0]           prdata_i,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Abort fires on the edge where the
  // count would reach TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ?
    CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e             r_state;
  state_e             w_next;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic               w_to;
  req_t               r_req;
  req_t               w_req;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic               r_err;
  logic               r_timeout;
  logic [CW-1:0]      r_cnt;

  rr_arb_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_sel (
    .i_req  (req_valid_i),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  assign w_any = |w_gnt;

  always_comb begin
    w_req.addr  = req_addr_i[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_req.write = req_write_i[w_idx];
    w_req.wdata = req_wdata_i[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
    w_req.strb  = req_strb_i[int'(w_idx)*SW +: SW];
  end

  assign w_to = (TIMEOUT_CYCLES > 0) &&
                !pready_i &&
                (r_cnt == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (pready_i || w_to) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    busy_o      = 1'b1;
    rsp_valid_o = '0;
    timeout_o   = 1'b0;
    unique case (r_state)
      IDLE:   busy_o = 1'b0;
      SETUP:  psel_o = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP: begin
        rsp_valid_o = NUM_REQ'(1) << r_idx;
        timeout_o   = r_timeout;
      end
      default: busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last    <= IW'(NUM_REQ - 1);
      r_idx     <= '0;
      r_req     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_idx  <= w_idx;
        r_last <= w_idx;
        r_req  <= w_req;
      end
      // Saturating, so a disabled watchdog
      // never wraps into a false abort.
      if (r_state == SETUP) begin
        r_cnt <= '0;
      end else if (r_state == ACCESS &&
                   !pready_i &&
                   r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == ACCESS) begin
        if (pready_i) begin
          r_rdata   <= prdata_i;
          r_err     <= pslverr_i;
          r_timeout <= 1'b0;
        end else if (w_to) begin
          r_rdata   <= '0;
          r_err     <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign paddr_o     = r_req.addr;
  assign pwrite_o    = r_req.write;
  assign pwdata_o    = r_req.wdata;
  assign pstrb_o     = r_req.strb;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter.
// u0 uses an 8-cycle watchdog, u1 has it disabled.
module tb_apb_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid;
  logic [23:0] req_addr;
  logic [1:0]  req_write;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel, penable, busy, tmo;

  logic [1:0]  b_req_valid;
  logic [23:0] b_req_addr;
  logic [1:0]  b_req_write;
  logic [63:0] b_req_wdata;
  logic [7:0]  b_req_strb;
  logic        b_pready, b_pslverr;
  logic [31:0] b_prdata;
  logic [1:0]  b_rsp_valid;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err;
  logic [11:0] b_paddr;
  logic        b_pwrite;
  logic [31:0] b_pwdata;
  logic [3:0]  b_pstrb;
  logic        b_psel, b_penable, b_busy, b_tmo;

  apb_rr_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(12),
    .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) u0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata),
    .req_strb_i(req_strb), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb),
    .psel_o(psel), .penable_o(penable),
    .pready_i(pready), .pslverr_i(pslverr),
    .prdata_i(prdata), .busy_o(busy),
    .timeout_o(tmo)
  );

  apb_rr_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(12),
    .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)
  ) u1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_addr_i(b_req_addr),
    .req_write_i(b_req_write), .req_wdata_i(b_req_wdata),
    .req_strb_i(b_req_strb), .rsp_valid_o(b_rsp_valid),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
    .paddr_o(b_paddr), .pwrite_o(b_pwrite),
    .pwdata_o(b_pwdata), .pstrb_o(b_pstrb),
    .psel_o(b_psel), .penable_o(b_penable),
    .pready_i(b_pready), .pslverr_i(b_pslverr),
    .prdata_i(b_prdata), .busy_o(b_busy),
    .timeout_o(b_tmo)
  );

  int n_chk = 0;
  int n_fail = 0;
  int proto_err = 0;
  int npulse;
  int bad;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i,
                         input logic [11:0] a,
                         input logic w,
                         input logic [31:0] d,
                         input logic [3:0] s);
    req_addr[i*12 +: 12]  = a;
    req_write[i]          = w;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]    = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // A request must stay up until its pulse.
  logic [1:0] pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        assert (!(pend[i] && !req_valid[i])) else begin
          proto_err <= proto_err + 1;
          $error("FAIL proto_drop req%0d: valid %0b required 1",
                 i, req_valid[i]);
        end
      end
      pend <= req_valid & ~rsp_valid;
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_addr = '0;
    req_write = '0; req_wdata = '0;
    req_strb = '0;
    pready = 1'b1; pslverr = 1'b0;
    prdata = '0;
    b_req_valid = '0; b_req_addr = '0;
    b_req_write = '0; b_req_wdata = '0;
    b_req_strb = '0;
    b_pready = 1'b0; b_pslverr = 1'b0;
    b_prdata = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_ctl",
        {psel, penable, rsp_valid, busy, tmo, rsp_err}, 0);
    chk("rst_data", {paddr, pwrite, pwdata, pstrb}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_u1",
        {b_psel, b_penable, b_rsp_valid, b_busy, b_tmo}, 0);
    rst = 1'b0;

    // 1: single write from req0
    set_req(0, 12'h010, 1'b1, 32'hDEADBEEF, 4'hF);
    req_valid = 2'b01;
    tick();
    chk("t1_setup", {psel, penable}, 2'b10);
    chk("t1_fields", {paddr, pwrite, pwdata, pstrb},
        {12'h010, 1'b1, 32'hDEADBEEF, 4'hF});
    tick();
    chk("t1_access", {psel, penable}, 2'b11);
    tick();
    chk("t1_rsp", {rsp_valid, rsp_err, psel, tmo},
        {2'b01, 1'b0, 1'b0, 1'b0});
    tick();
    req_valid = 2'b00;
    chk("t1_idle", busy, 0);

    // 2: both held, alternate from req0
    do_reset();
    set_req(0, 12'h100, 1'b1, 32'h11110000, 4'hF);
    set_req(1, 12'h200, 1'b0, 32'h0, 4'h0);
    req_valid = 2'b11;
    npulse = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (rsp_valid != 2'b00) npulse++;
      if (c % 4 == 1)
        chk("t2_grant", {psel, penable, paddr},
            {2'b10, (c % 8 == 1) ? 12'h100 : 12'h200});
      if (c % 4 == 3)
        chk("t2_order", rsp_valid,
            (c == 3 || c == 11) ? 2'b01 : 2'b10);
      if (c == 12) req_valid[0] = 1'b0;
    end
    req_valid = 2'b00;
    chk("t2_count", npulse, 4);
    chk("t2_idle", busy, 0);

    // 3: req1 read, slow slave, pslverr
    set_req(1, 12'h0FC, 1'b0, 32'h0, 4'h0);
    pready = 1'b0; pslverr = 1'b1;
    prdata = 32'hBAD0BAD0;
    req_valid = 2'b10;
    tick();
    chk("t3_setup", {psel, penable, paddr, pwrite},
        {2'b10, 12'h0FC, 1'b0});
    req_addr[12 +: 12] = 12'h333;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t3_access", {rsp_valid, psel, penable, paddr},
          {2'b00, 2'b11, 12'h0FC});
    end
    pready = 1'b1;
    prdata = 32'h12345678;
    tick();
    chk("t3_rsp", {rsp_valid, rsp_err, rsp_rdata, psel},
        {2'b10, 1'b1, 32'h12345678, 1'b0});
    tick();
    req_valid = 2'b00;
    pslverr = 1'b0;
    chk("t3_idle", {busy, tmo}, 0);

    // 4: watchdog abort, then pending req1
    set_req(0, 12'h020, 1'b0, 32'h0, 4'h0);
    set_req(1, 12'h040, 1'b1, 32'hCAFEF00D, 4'h3);
    pready = 1'b0;
    prdata = 32'hFFFFFFFF;
    req_valid = 2'b11;
    tick();
    chk("t4_setup", {psel, penable, paddr},
        {2'b10, 12'h020});
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t4_wait", {psel, penable, tmo, rsp_valid},
          {2'b11, 1'b0, 2'b00});
    end
    tick();
    chk("t4_abort",
        {psel, penable, rsp_valid, rsp_err, tmo, rsp_rdata},
        {2'b00, 2'b01, 1'b1, 1'b1, 32'h0});
    pready = 1'b1;
    prdata = 32'h0;
    tick();
    req_valid[0] = 1'b0;
    chk("t4_tmo_pulse", {tmo, busy}, 0);
    tick();
    chk("t4_next", {psel, paddr, pwrite, pwdata, pstrb},
        {1'b1, 12'h040, 1'b1, 32'hCAFEF00D, 4'h3});
    tick();
    tick();
    chk("t4_rsp", {rsp_valid, rsp_err, tmo},
        {2'b10, 1'b0, 1'b0});
    tick();
    req_valid = 2'b00;

    // 5: reset in the middle of req1 ACCESS
    set_req(1, 12'h0F0, 1'b0, 32'h0, 4'h0);
    set_req(0, 12'h00C, 1'b1, 32'hA5A5A5A5, 4'hF);
    pready = 1'b0;
    req_valid = 2'b10;
    tick();
    chk("t5_setup1", {psel, paddr}, {1'b1, 12'h0F0});
    tick();
    req_valid = 2'b11;
    chk("t5_access1", {psel, penable}, 2'b11);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_async",
        {psel, penable, rsp_valid, busy}, 0);
    pready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("t5_req0_first", {psel, penable, paddr},
        {2'b10, 12'h00C});
    tick();
    tick();
    chk("t5_rsp0", {rsp_valid, rsp_err}, {2'b01, 1'b0});
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk("t5_setup1b", {psel, paddr}, {1'b1, 12'h0F0});
    tick();
    tick();
    chk("t5_rsp1", rsp_valid, 2'b10);
    tick();
    req_valid = 2'b00;

    // 6: watchdog disabled, 1000 slow cycles
    b_req_addr[11:0] = 12'h0AA;
    b_req_write = 2'b01;
    b_req_wdata[31:0] = 32'h00000055;
    b_req_strb[3:0] = 4'h3;
    b_pready = 1'b0;
    b_req_valid = 2'b01;
    tick();
    chk("t6_setup", {b_psel, b_penable, b_paddr},
        {2'b10, 12'h0AA});
    tick();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!(b_psel && b_penable) || b_tmo ||
          b_rsp_valid != 2'b00)
        bad++;
      tick();
    end
    chk("t6_no_abort", bad, 0);
    chk("t6_still_access", {b_psel, b_penable}, 2'b11);
    b_pready = 1'b1;
    tick();
    chk("t6_rsp", {b_rsp_valid, b_rsp_err, b_tmo},
        {2'b01, 1'b0, 1'b0});
    tick();
    b_req_valid = 2'b00;
    chk("t6_idle", {b_busy, b_tmo}, 0);

    chk("protocol", proto_err, 0);
    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
